// File: rtl/axi_rd_burst_splitter.sv
// AXI4 read burst splitter: reissues upstream bursts of up to 256 beats as downstream
// sub-bursts of at most MAX_BEATS beats. Optional macro AXI_RD_SPLIT_ERR_STICKY_EN.
module axi_rd_burst_splitter #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MAX_BEATS  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   // Upstream AR
   input  logic [ID_WIDTH-1:0]   S_ARID,
   input  logic [ADDR_WIDTH-1:0] S_ARADDR,
   input  logic [7:0]            S_ARLEN,
   input  logic [2:0]            S_ARSIZE,
   input  logic [1:0]            S_ARBURST,
   input  logic                  S_ARVALID,
   output logic                  S_ARREADY,
   // Upstream R
   output logic [ID_WIDTH-1:0]   S_RID,
   output logic [DATA_WIDTH-1:0] S_RDATA,
   output logic [1:0]            S_RRESP,
   output logic                  S_RLAST,
   output logic                  S_RVALID,
   input  logic                  S_RREADY,
   // Downstream AR
   output logic [ID_WIDTH-1:0]   M_ARID,
   output logic [ADDR_WIDTH-1:0] M_ARADDR,
   output logic [7:0]            M_ARLEN,
   output logic [2:0]            M_ARSIZE,
   output logic [1:0]            M_ARBURST,
   output logic                  M_ARVALID,
   input  logic                  M_ARREADY,
   // Downstream R
   input  logic [ID_WIDTH-1:0]   M_RID,
   input  logic [DATA_WIDTH-1:0] M_RDATA,
   input  logic [1:0]            M_RRESP,
   input  logic                  M_RLAST,
   input  logic                  M_RVALID,
   output logic                  M_RREADY
);

   typedef enum logic [1:0] {StIdle, StIssue, StData} state_e;

   localparam logic [1:0] BurstIncr = 2'd1;
   localparam logic [8:0] MaxBeats  = 9'(MAX_BEATS);

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [8:0]            remaining_q, remaining_d;
   logic [8:0]            sub_beats_q, sub_beats_d;

   logic [8:0]            next_beats;
   logic [ADDR_WIDTH-1:0] addr_step;
   logic                  r_hs;
   logic                  last_hs;
   logic                  final_sub;
   logic                  unused_rid;

   // The downstream slave echoes our ID; the latched upstream ID is returned instead.
   assign unused_rid = ^M_RID;

   assign next_beats = (remaining_q > MaxBeats) ? MaxBeats : remaining_q;
   assign addr_step  = ADDR_WIDTH'(sub_beats_q) << size_q;
   assign r_hs       = (state_q == StData) && M_RVALID && S_RREADY;
   assign last_hs    = r_hs && M_RLAST;
   assign final_sub  = (remaining_q == sub_beats_q);

   always_comb begin
      S_ARREADY = (state_q == StIdle) && !ARESET;
      M_ARVALID = (state_q == StIssue);
      M_ARID    = id_q;
      M_ARADDR  = addr_q;
      M_ARLEN   = 8'(next_beats - 9'd1);
      M_ARSIZE  = size_q;
      M_ARBURST = burst_q;
      M_RREADY  = (state_q == StData) && S_RREADY;
      S_RVALID  = (state_q == StData) && M_RVALID;
      S_RID     = id_q;
      S_RDATA   = M_RDATA;
      // Intermediate sub-burst RLASTs are hidden from the upstream master.
      S_RLAST   = (state_q == StData) && M_RLAST && final_sub;
   end

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      size_d      = size_q;
      burst_d     = burst_q;
      remaining_d = remaining_q;
      sub_beats_d = sub_beats_q;
      unique case (state_q)
         StIdle: begin
            if (S_ARVALID) begin
               id_d        = S_ARID;
               addr_d      = S_ARADDR;
               size_d      = S_ARSIZE;
               burst_d     = S_ARBURST;
               remaining_d = {1'b0, S_ARLEN} + 9'd1;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (M_ARREADY) begin
               sub_beats_d = next_beats;
               state_d     = StData;
            end
         end
         StData: begin
            if (last_hs) begin
               remaining_d = remaining_q - sub_beats_q;
               if (final_sub) begin
                  state_d = StIdle;
               end else begin
                  // FIXED re-reads the same address; WRAP never gets here (single sub-burst).
                  if (burst_q == BurstIncr) begin
                     addr_d = addr_q + addr_step;
                  end
                  state_d = StIssue;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= StIdle;
         id_q        <= '0;
         addr_q      <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         remaining_q <= '0;
         sub_beats_q <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         remaining_q <= remaining_d;
         sub_beats_q <= sub_beats_d;
      end
   end

`ifdef AXI_RD_SPLIT_ERR_STICKY_EN
   logic [1:0] err_q, err_d;

   // First SLVERR/DECERR of a burst is held until the upstream last beat.
   always_comb begin
      err_d = err_q;
      if (r_hs) begin
         if (S_RLAST) begin
            err_d = 2'b00;
         end else if ((err_q == 2'b00) && M_RRESP[1]) begin
            err_d = M_RRESP;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         err_q <= 2'b00;
      end else begin
         err_q <= err_d;
      end
   end

   assign S_RRESP = (err_q > M_RRESP) ? err_q : M_RRESP;
`else
   assign S_RRESP = M_RRESP;
`endif

endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// Randomized bench for axi_rd_burst_splitter with a burst-level reference model and
// a simple downstream slave; honours AXI_RD_SPLIT_ERR_STICKY_EN for expected responses.
module tb_axi_rd_burst_splitter;

   localparam int unsigned IdW      = 4;
   localparam int unsigned AddrW    = 32;
   localparam int unsigned DataW    = 64;
   localparam int unsigned MaxBeats = 16;

   logic             ACLK = 1'b0;
   logic             ARESET;
   logic [IdW-1:0]   S_ARID;
   logic [AddrW-1:0] S_ARADDR;
   logic [7:0]       S_ARLEN;
   logic [2:0]       S_ARSIZE;
   logic [1:0]       S_ARBURST;
   logic             S_ARVALID;
   logic             S_ARREADY;
   logic [IdW-1:0]   S_RID;
   logic [DataW-1:0] S_RDATA;
   logic [1:0]       S_RRESP;
   logic             S_RLAST;
   logic             S_RVALID;
   logic             S_RREADY;
   logic [IdW-1:0]   M_ARID;
   logic [AddrW-1:0] M_ARADDR;
   logic [7:0]       M_ARLEN;
   logic [2:0]       M_ARSIZE;
   logic [1:0]       M_ARBURST;
   logic             M_ARVALID;
   logic             M_ARREADY;
   logic [IdW-1:0]   M_RID;
   logic [DataW-1:0] M_RDATA;
   logic [1:0]       M_RRESP;
   logic             M_RLAST;
   logic             M_RVALID;
   logic             M_RREADY;

   always #5 ACLK = ~ACLK;

   axi_rd_burst_splitter #(
      .ID_WIDTH  (IdW),
      .ADDR_WIDTH(AddrW),
      .DATA_WIDTH(DataW),
      .MAX_BEATS (MaxBeats)
   ) u_dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .S_ARID   (S_ARID),
      .S_ARADDR (S_ARADDR),
      .S_ARLEN  (S_ARLEN),
      .S_ARSIZE (S_ARSIZE),
      .S_ARBURST(S_ARBURST),
      .S_ARVALID(S_ARVALID),
      .S_ARREADY(S_ARREADY),
      .S_RID    (S_RID),
      .S_RDATA  (S_RDATA),
      .S_RRESP  (S_RRESP),
      .S_RLAST  (S_RLAST),
      .S_RVALID (S_RVALID),
      .S_RREADY (S_RREADY),
      .M_ARID   (M_ARID),
      .M_ARADDR (M_ARADDR),
      .M_ARLEN  (M_ARLEN),
      .M_ARSIZE (M_ARSIZE),
      .M_ARBURST(M_ARBURST),
      .M_ARVALID(M_ARVALID),
      .M_ARREADY(M_ARREADY),
      .M_RID    (M_RID),
      .M_RDATA  (M_RDATA),
      .M_RRESP  (M_RRESP),
      .M_RLAST  (M_RLAST),
      .M_RVALID (M_RVALID),
      .M_RREADY (M_RREADY)
   );

   typedef struct {
      logic [IdW-1:0]   id;
      logic [AddrW-1:0] addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      int               err_beat;
      logic [1:0]       err_code;
      int               ar_mode;  // 0 random M_ARREADY, 1 five-cycle stall
      int               r_mode;   // 0 random, 1 toggle, 2 always ready
   } req_t;

   typedef struct {
      logic [AddrW-1:0] addr;
      logic [7:0]       len;
   } sub_t;

   typedef struct {
      logic [DataW-1:0] data;
      logic             last;
      logic [1:0]       resp;
   } beat_t;

   req_t  req_q[$];
   sub_t  sub_q[$];
   beat_t beat_q[$];
   req_t  cur;

   int n_cmp = 0;
   int n_err = 0;

   bit          busy;
   bit          exp_arv;
   bit          ar_hold;
   logic [63:0] ar_saved;
   int          ar_wait;
   int          cur_tag;
   bit          sl_active;
   int          sl_left;
   int          sl_beat;
   bit          rv_pending;
   bit          rr_tog;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DataW-1:0] beat_data(input int tag, input int idx);
      return (64'(tag) << 32) | 64'(idx);
   endfunction

   // Reference: split the burst into MAX_BEATS chunks and list every upstream beat.
   task automatic model_accept(input req_t r);
      int               rem;
      int               n;
      logic [AddrW-1:0] a;
      sub_t             s;
      beat_t            b;
      bit               sticky;
`ifdef AXI_RD_SPLIT_ERR_STICKY_EN
      sticky = 1'b1;
`else
      sticky = 1'b0;
`endif
      rem = int'(r.len) + 1;
      a   = r.addr;
      if (r.burst == 2'd2) begin
         s.addr = a;
         s.len  = r.len;
         sub_q.push_back(s);
      end else begin
         while (rem > 0) begin
            n      = (rem > int'(MaxBeats)) ? int'(MaxBeats) : rem;
            s.addr = a;
            s.len  = 8'(n - 1);
            sub_q.push_back(s);
            if (r.burst == 2'd1) a = a + (32'(n) << r.size);
            rem -= n;
         end
      end
      for (int i = 0; i <= int'(r.len); i++) begin
         b.data = beat_data(cur_tag, i);
         b.last = (i == int'(r.len));
         if (r.err_beat >= 0 && (sticky ? (i >= r.err_beat) : (i == r.err_beat)))
            b.resp = r.err_code;
         else
            b.resp = 2'b00;
         beat_q.push_back(b);
      end
   endtask

   task automatic drive();
      if (req_q.size() > 0) begin
         S_ARVALID = 1'b1;
         S_ARID    = req_q[0].id;
         S_ARADDR  = req_q[0].addr;
         S_ARLEN   = req_q[0].len;
         S_ARSIZE  = req_q[0].size;
         S_ARBURST = req_q[0].burst;
      end else begin
         S_ARVALID = 1'b0;
      end
      M_ARREADY = (cur.ar_mode == 1) ? (ar_wait >= 5) : ($urandom_range(3) != 0);
      rr_tog = ~rr_tog;
      case (cur.r_mode)
         1:       S_RREADY = rr_tog;
         2:       S_RREADY = 1'b1;
         default: S_RREADY = ($urandom_range(9) < 7);
      endcase
      M_RID = 4'($urandom);
      if (sl_active) begin
         if (!rv_pending) M_RVALID = ($urandom_range(4) != 0);
         M_RDATA = beat_data(cur_tag, sl_beat);
         M_RLAST = (sl_left == 1);
         M_RRESP = (sl_beat == cur.err_beat) ? cur.err_code : 2'b00;
      end else begin
         // Stray traffic that must never be consumed.
         M_RVALID = ($urandom_range(9) == 0);
         M_RDATA  = {32'($urandom), 32'($urandom)};
         M_RLAST  = 1'($urandom);
         M_RRESP  = 2'($urandom);
      end
   endtask

   task automatic observe();
      sub_t  s;
      beat_t b;
      if (exp_arv) begin
         check("m_arvalid_next_cycle", M_ARVALID, 1);
         exp_arv = 1'b0;
      end
      if (ar_hold)
         check("m_ar_stable", {M_ARVALID, M_ARADDR, M_ARLEN, M_ARID, M_ARSIZE, M_ARBURST}, ar_saved);
      ar_hold  = M_ARVALID && !M_ARREADY;
      ar_saved = {M_ARVALID, M_ARADDR, M_ARLEN, M_ARID, M_ARSIZE, M_ARBURST};
      if (M_ARVALID && !M_ARREADY) ar_wait++;
      check("s_arready", S_ARREADY, !busy);
      if (!sl_active) begin
         check("s_rvalid_outside_data", S_RVALID, 0);
         if (M_RVALID) check("m_rready_outside_data", M_RREADY, 0);
      end else begin
         check("m_rready_pass", M_RREADY, S_RREADY);
      end
      rv_pending = M_RVALID && !M_RREADY && sl_active;

      if (S_ARVALID && S_ARREADY) begin
         cur = req_q.pop_front();
         cur_tag++;
         model_accept(cur);
         busy    = 1'b1;
         exp_arv = 1'b1;
         sl_beat = 0;
         ar_wait = 0;
      end

      if (M_ARVALID && M_ARREADY) begin
         ar_wait = 0;
         if (sub_q.size() == 0) begin
            check("unexpected_m_ar", 1, 0);
         end else begin
            s = sub_q.pop_front();
            check("m_araddr", M_ARADDR, s.addr);
            check("m_arlen", M_ARLEN, s.len);
            check("m_arid", M_ARID, cur.id);
            check("m_arsize", M_ARSIZE, cur.size);
            check("m_arburst", M_ARBURST, cur.burst);
            sl_active = 1'b1;
            sl_left   = int'(s.len) + 1;
         end
      end

      if (sl_active && M_RVALID && M_RREADY) begin
         check("s_rvalid_pass", S_RVALID, 1);
         if (beat_q.size() == 0) begin
            check("extra_beat", 1, 0);
         end else begin
            b = beat_q.pop_front();
            check("s_rdata", S_RDATA, b.data);
            check("s_rlast", S_RLAST, b.last);
            check("s_rresp", S_RRESP, b.resp);
            check("s_rid", S_RID, cur.id);
            if (b.last) busy = 1'b0;
         end
         sl_beat++;
         sl_left--;
         if (sl_left == 0) begin
            sl_active  = 1'b0;
            rv_pending = 1'b0;
            if (sub_q.size() > 0) exp_arv = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      drive();
      @(negedge ACLK);
      observe();
      @(posedge ACLK);
      #1;
   endtask

   task automatic run_until_idle(input int max_cycles);
      int n = 0;
      while ((req_q.size() > 0 || busy) && n < max_cycles) begin
         cycle();
         n++;
      end
      check("burst_completed", (req_q.size() > 0 || busy), 0);
   endtask

   task automatic run_until_beats(input int k, input int max_cycles);
      int n = 0;
      while (sl_beat < k && n < max_cycles) begin
         cycle();
         n++;
      end
      check("beats_reached", (sl_beat >= k), 1);
   endtask

   task automatic clear_model();
      sub_q.delete();
      beat_q.delete();
      busy       = 1'b0;
      exp_arv    = 1'b0;
      ar_hold    = 1'b0;
      ar_wait    = 0;
      sl_active  = 1'b0;
      sl_left    = 0;
      rv_pending = 1'b0;
   endtask

   task automatic do_reset();
      ARESET    = 1'b1;
      S_ARVALID = 1'b0;
      M_ARREADY = 1'b0;
      M_RVALID  = 1'b1;
      S_RREADY  = 1'b1;
      @(negedge ACLK);
      check("rst_s_arready_low", S_ARREADY, 0);
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      clear_model();
      @(negedge ACLK);
      check("post_rst_m_arvalid", M_ARVALID, 0);
      check("post_rst_s_rvalid", S_RVALID, 0);
      check("post_rst_m_rready", M_RREADY, 0);
      check("post_rst_s_arready", S_ARREADY, 1);
      @(posedge ACLK);
      #1;
   endtask

   function automatic req_t mk(input logic [IdW-1:0] id, input logic [AddrW-1:0] addr,
                               input int len, input int size, input int burst,
                               input int err_beat, input int ar_mode, input int r_mode);
      req_t r;
      r.id       = id;
      r.addr     = addr;
      r.len      = 8'(len);
      r.size     = 3'(size);
      r.burst    = 2'(burst);
      r.err_beat = err_beat;
      r.err_code = 2'd2;
      r.ar_mode  = ar_mode;
      r.r_mode   = r_mode;
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t             r;
      int               total;
      logic [AddrW-1:0] base;
      r.id      = 4'($urandom);
      r.burst   = 2'($urandom_range(2));
      r.size    = 3'($urandom_range(3));
      r.ar_mode = ($urandom_range(5) == 0) ? 1 : 0;
      r.r_mode  = $urandom_range(2);
      if (r.burst == 2'd2) begin
         case ($urandom_range(3))
            0:       r.len = 8'd1;
            1:       r.len = 8'd3;
            2:       r.len = 8'd7;
            default: r.len = 8'd15;
         endcase
      end else begin
         r.len = ($urandom_range(1) == 1) ? 8'($urandom_range(255)) : 8'($urandom_range(40));
      end
      total  = (int'(r.len) + 1) << r.size;
      base   = 32'($urandom) & 32'hFFFF_F000;
      // Keep INCR bursts inside one 4 KB page.
      r.addr = base + ((32'($urandom_range(4096 - total))) & ~((32'd1 << r.size) - 32'd1));
      r.err_beat = ($urandom_range(3) == 0) ? $urandom_range(int'(r.len)) : -1;
      r.err_code = ($urandom_range(1) == 1) ? 2'd3 : 2'd2;
      return r;
   endfunction

   initial begin
      ARESET    = 1'b1;
      S_ARID    = '0;
      S_ARADDR  = '0;
      S_ARLEN   = '0;
      S_ARSIZE  = '0;
      S_ARBURST = '0;
      S_ARVALID = 1'b0;
      S_RREADY  = 1'b1;
      M_ARREADY = 1'b0;
      M_RID     = '0;
      M_RDATA   = '0;
      M_RRESP   = '0;
      M_RLAST   = 1'b0;
      M_RVALID  = 1'b1;
      cur       = mk(0, 0, 0, 0, 1, -1, 0, 2);
      cur_tag   = 0;
      sl_beat   = 0;
      rr_tog    = 1'b0;
      clear_model();

      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_s_arready", S_ARREADY, 0);
      check("rst_m_arvalid", M_ARVALID, 0);
      check("rst_s_rvalid", S_RVALID, 0);
      check("rst_m_rready", M_RREADY, 0);
      @(posedge ACLK);
      #1;
      ARESET   = 1'b0;
      M_RVALID = 1'b0;
      @(negedge ACLK);
      check("rst_release_s_arready", S_ARREADY, 1);
      @(posedge ACLK);
      #1;

      // Single sub-burst, then a three-way INCR split.
      req_q.push_back(mk(4'h3, 32'h1000, 3, 3, 1, -1, 0, 2));
      run_until_idle(500);
      req_q.push_back(mk(4'h5, 32'h2000, 39, 3, 1, -1, 0, 0));
      run_until_idle(2000);
      // FIXED split, then WRAP pass-through.
      req_q.push_back(mk(4'h6, 32'h3008, 19, 3, 0, -1, 0, 0));
      req_q.push_back(mk(4'h7, 32'h4010, 15, 3, 2, -1, 0, 0));
      run_until_idle(2000);
      // AR stall + toggling RREADY with the next request queued behind it,
      // then an error on beat 5 followed by a clean burst.
      req_q.push_back(mk(4'h8, 32'h5000, 39, 3, 1, -1, 1, 1));
      req_q.push_back(mk(4'h9, 32'h6000, 39, 3, 1, 4, 0, 0));
      req_q.push_back(mk(4'hA, 32'h7000, 7, 3, 1, -1, 0, 0));
      run_until_idle(4000);
      // Reset mid-burst, then a one-beat burst.
      req_q.push_back(mk(4'hB, 32'h8000, 39, 3, 1, -1, 0, 2));
      run_until_beats(10, 1000);
      do_reset();
      req_q.push_back(mk(4'hC, 32'h9000, 0, 3, 1, -1, 0, 2));
      run_until_idle(500);

      for (int i = 0; i < 30; i++) begin
         req_q.push_back(rand_req());
         if ($urandom_range(1) == 1) req_q.push_back(rand_req());
         run_until_idle(5000);
      end
      check("beats_outstanding", beat_q.size(), 0);
      check("subs_outstanding", sub_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_rd_burst_splitter.md
Name: axi_rd_burst_splitter

Overview:
AXI4 read-channel stage between the TLX master domain's AXI master read port and the AxiSram read port. It accepts upstream read bursts of up to 256 beats and reissues them downstream as consecutive sub-bursts of at most MAX_BEATS beats. Downstream RLAST is merged so the upstream master sees one RLAST per original burst. One upstream burst is in flight at a time.

Parameters:
ID_WIDTH, 4, width of ARID/RID
ADDR_WIDTH, 32, address width
DATA_WIDTH, 64, R data width
MAX_BEATS, 16, maximum downstream burst length; power of 2, 16..256

Ports:
ACLK  in  1  clock for both sides
ARESET  in  1  synchronous, active-high reset
S_ARID  in  ID_WIDTH  upstream read ID
S_ARADDR  in  ADDR_WIDTH  upstream start address
S_ARLEN  in  8  upstream beats-1
S_ARSIZE  in  3  bytes per beat, log2
S_ARBURST  in  2  0=FIXED, 1=INCR, 2=WRAP
S_ARVALID  in  1  upstream AR valid
S_ARREADY  out  1  upstream AR ready
S_RID  out  ID_WIDTH  latched upstream ID
S_RDATA  out  DATA_WIDTH  read data
S_RRESP  out  2  read response
S_RLAST  out  1  last beat of upstream burst
S_RVALID  out  1  upstream R valid
S_RREADY  in  1  upstream R ready
M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID  out  as S_  downstream AR
M_ARREADY  in  1  downstream AR ready
M_RID  in  ID_WIDTH  ignored
M_RDATA  in  DATA_WIDTH; M_RRESP  in  2; M_RLAST  in  1; M_RVALID  in  1  downstream R
M_RREADY  out  1  downstream R ready

Behaviour:
- One clock, ACLK. ARESET is synchronous and active-high.
- FSM states: IDLE, ISSUE, DATA.
- IDLE: S_ARREADY=1.
  - On S_ARVALID&S_ARREADY, latch id/addr/size/burst. Set remaining = S_ARLEN+1 (9-bit, range 1..256). Go to ISSUE.
- ISSUE: M_ARVALID=1 with cur_addr and M_ARLEN = min(remaining, MAX_BEATS)-1. M_ARID = latched ID; M_ARSIZE and M_ARBURST are passed through.
  - Payload is held stable until M_ARREADY.
  - On the handshake, record sub_beats and go to DATA.
- DATA: R path is combinational and zero-latency.
  - S_RVALID = M_RVALID, M_RREADY = S_RREADY, S_RDATA = M_RDATA, S_RRESP = M_RRESP, S_RID = latched ID.
  - S_RLAST = M_RLAST & (remaining == sub_beats).
- On the M_RLAST beat handshake:
  - remaining -= sub_beats.
  - If remaining becomes 0, go to IDLE.
  - Otherwise update cur_addr and go to ISSUE. M_ARVALID asserts in the cycle after the last-beat handshake.
- Address update:
  - INCR: cur_addr += sub_beats << size, ADDR_WIDTH modulo. Upstream guarantees no 4 KB crossing.
  - FIXED: cur_addr unchanged.
- WRAP bursts (len ≤ 16 ≤ MAX_BEATS) are forwarded unchanged as a single sub-burst.
- Outside DATA: S_RVALID=0 and M_RREADY=0. A stray M_RVALID is not consumed.
- Outside IDLE: S_ARREADY=0. No new upstream AR is accepted until the final beat has been handshaken.
- Latency: upstream AR accepted in cycle N → M_ARVALID in cycle N+1.
- Reset values: state=IDLE, M_ARVALID=0, S_RVALID=0, M_RREADY=0, remaining=0, latched regs=0. S_ARREADY=0 while ARESET is high, then 1 in the first cycle after.
- Reset mid-burst: abandons the burst immediately and returns to IDLE. The downstream slave shares ARESET and is reset in the same cycle.
- Simultaneous events: the final-beat handshake and a new S_ARVALID in the same cycle are not both taken. The new AR is accepted the next cycle, in IDLE.

Optional Feature:
- Macro AXI_RD_SPLIT_ERR_STICKY_EN.
- Defined: the first beat with M_RRESP ≥ 2 records the response (SLVERR=2 or DECERR=3). That beat and all later beats of the same upstream burst report S_RRESP = max(recorded, M_RRESP). The record clears on upstream last beat or on reset.
- Undefined: S_RRESP = M_RRESP per beat, with no state.

Test Plan:
1. INCR ARADDR=0x1000, ARLEN=3, ARSIZE=3, MAX_BEATS=16 → one M_AR (0x1000, len 3). 4 beats, S_RLAST on beat 4 only. M_ARVALID one cycle after S_AR handshake.
2. INCR 0x2000, ARLEN=39, ARSIZE=3 → M_AR sequence (0x2000,15), (0x2080,15), (0x2100,7). M_RLAST at beats 16 and 32 is suppressed; S_RLAST only at beat 40. S_RID equals S_ARID on all beats.
3. FIXED 0x3008, ARLEN=19 → M_AR (0x3008,15) then (0x3008,3), 20 beats. Then WRAP 0x4010, ARLEN=15 → single M_AR identical to upstream.
4. Backpressure: M_ARREADY low for 5 cycles → M_ARVALID and payload stable. S_RREADY toggling every other cycle over 40 beats → all 40 data values delivered in order, none duplicated. S_ARVALID held during DATA → S_ARREADY stays 0.
5. 40-beat burst with beat 5 returning RRESP=2 → with the macro, beats 5..40 report 2 and the next burst reports 0. Without it, only beat 5 reports 2.
6. ARESET pulsed during beat 10 of a 40-beat burst → next cycle: IDLE, M_ARVALID=0, S_RVALID=0. A new ARLEN=0 burst then completes normally with one beat and S_RLAST=1.
